// File: rtl/vx_fifo_unpacker.sv
// vx_fifo_unpacker
// Drains a show-ahead FIFO of wide entries and emits each entry as RATIO
// narrow beats on a valid/ready stream, tagging the final beat of each entry.
// Back-to-back entries stream without bubbles: the next entry is popped on
// the same edge that retires the current entry's last beat.

module vx_fifo_unpacker #(
    parameter int unsigned DATAW     = 64,
    parameter int unsigned RATIO     = 4,
    parameter bit          LSB_FIRST = 1'b1,
    localparam int unsigned OUTW     = DATAW / RATIO,
    localparam int unsigned CNTW     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATAW-1:0]  fifo_data,
    output logic              fifo_pop,
    output logic              valid_out,
    output logic [OUTW-1:0]   data_out,
    output logic              last_out,
    output logic [CNTW-1:0]   beat_idx,
    input  logic              ready_out
);

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(RATIO - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [DATAW-1:0]  r_entry;
    logic [DATAW-1:0]  w_entry_nxt;
    logic [CNTW-1:0]   r_cnt;
    logic [CNTW-1:0]   w_cnt_nxt;

    logic              w_busy;
    logic              w_at_last;
    logic              w_fire;
    logic              w_done;
    logic              w_pop;

    // Beat slices of the held entry, already arranged in emission order
    logic [OUTW-1:0]   w_slices [RATIO];

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        if (LSB_FIRST) begin : g_lsb
            assign w_slices[g] = r_entry[g*OUTW +: OUTW];
        end else begin : g_msb
            assign w_slices[g] = r_entry[(RATIO-1-g)*OUTW +: OUTW];
        end
    end

    // Handshake qualifiers shared by the next-state logic and the outputs
    always_comb begin
        w_busy    = (r_state == S_ACTIVE);
        w_at_last = (r_cnt == LAST_IDX);
        w_fire    = w_busy & ready_out;
        w_done    = w_fire & w_at_last;
        w_pop     = ~reset & ~fifo_empty & (~w_busy | w_done);
    end

    // Next-state: load on pop, advance on fire, retire on the last fire
    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        w_cnt_nxt   = r_cnt;
        if (w_pop) begin
            w_state_nxt = S_ACTIVE;
            w_entry_nxt = fifo_data;
            w_cnt_nxt   = '0;
        end else if (w_done) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_fire) begin
            w_cnt_nxt   = r_cnt + CNTW'(1);
        end
    end

    // State, held entry and beat counter; reset discards any partial entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_entry <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_entry <= w_entry_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stream outputs decode straight from the registered state
    always_comb begin
        fifo_pop  = w_pop;
        valid_out = w_busy;
        data_out  = w_slices[r_cnt];
        last_out  = w_busy & w_at_last;
        beat_idx  = r_cnt;
    end

endmodule

// File: tb/tb_vx_fifo_unpacker.sv
// tb_vx_fifo_unpacker
// Three builds side by side (LSB-first RATIO=4, MSB-first RATIO=4, RATIO=1),
// each fed from its own view of one shared FIFO content list. A per-build
// model tracks the held entry and its remaining beat count.

module tb_vx_fifo_unpacker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b0;
    logic        chk_en = 1'b0;

    logic        emp  [3] = '{1'b1, 1'b1, 1'b1};
    logic [63:0] fdat [3] = '{64'd0, 64'd0, 64'd0};
    logic        pop_o   [3];
    logic        valid_o [3];
    logic        last_o  [3];
    logic [63:0] w_data  [3];
    logic [7:0]  w_idx   [3];

    logic [15:0] d0_data;
    logic [15:0] d1_data;
    logic [63:0] d2_data;
    logic [1:0]  d0_idx;
    logic [1:0]  d1_idx;
    logic [0:0]  d2_idx;

    int          ratio_k [3] = '{4, 4, 1};
    bit          lsb_k   [3] = '{1'b1, 1'b0, 1'b1};

    logic [63:0] ent [$];
    int          rd  [3] = '{0, 0, 0};
    int          rem [3] = '{0, 0, 0};
    logic [63:0] cur [3] = '{64'd0, 64'd0, 64'd0};

    bit          s_reset;
    bit          s_fire [3];
    bit          s_pop  [3];
    int          cyc;

    logic [63:0] log_d0 [$];
    logic [63:0] log_d1 [$];
    logic [63:0] log_d2 [$];
    int          log_c0 [$];
    int          log_c2 [$];
    int          log_p0 [$];

    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    vx_fifo_unpacker #(.DATAW(64), .RATIO(4), .LSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .fifo_empty(emp[0]), .fifo_data(fdat[0]),
        .fifo_pop(pop_o[0]), .valid_out(valid_o[0]), .data_out(d0_data),
        .last_out(last_o[0]), .beat_idx(d0_idx), .ready_out(ready)
    );

    vx_fifo_unpacker #(.DATAW(64), .RATIO(4), .LSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .fifo_empty(emp[1]), .fifo_data(fdat[1]),
        .fifo_pop(pop_o[1]), .valid_out(valid_o[1]), .data_out(d1_data),
        .last_out(last_o[1]), .beat_idx(d1_idx), .ready_out(ready)
    );

    vx_fifo_unpacker #(.DATAW(64), .RATIO(1), .LSB_FIRST(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .fifo_empty(emp[2]), .fifo_data(fdat[2]),
        .fifo_pop(pop_o[2]), .valid_out(valid_o[2]), .data_out(d2_data),
        .last_out(last_o[2]), .beat_idx(d2_idx), .ready_out(ready)
    );

    assign w_data[0] = 64'(d0_data);
    assign w_data[1] = 64'(d1_data);
    assign w_data[2] = d2_data;
    assign w_idx[0]  = 8'(d0_idx);
    assign w_idx[1]  = 8'(d1_idx);
    assign w_idx[2]  = 8'(d2_idx);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Beat b of entry e for build k, from slice width and emission order
    function automatic logic [63:0] beat_of(input logic [63:0] e, input int k, input int b);
        int          w;
        int          s;
        logic [63:0] m;
        w = 64 / ratio_k[k];
        s = lsb_k[k] ? b : (ratio_k[k] - 1 - b);
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        return (e >> (s * w)) & m;
    endfunction

    function automatic bit all_done();
        bit d;
        d = 1'b1;
        for (int k = 0; k < 3; k++)
            if (rd[k] != ent.size() || rem[k] != 0) d = 1'b0;
        return d;
    endfunction

    // Sample outputs mid-cycle and compare against the model
    always @(negedge clk) begin
        bit busy;
        bit avail;
        bit exp_pop;
        int b;
        cyc = cyc + 1;
        s_reset = reset;
        for (int k = 0; k < 3; k++) begin
            busy  = (rem[k] != 0);
            avail = (rd[k] < ent.size());
            if (chk_en) begin
                exp_pop = !reset && avail && (!busy || (ready && rem[k] == 1));
                chk($sformatf("pop[%0d]", k), 64'(pop_o[k]), 64'(exp_pop));
                chk($sformatf("valid[%0d]", k), 64'(valid_o[k]), 64'(busy));
                if (busy) begin
                    b = ratio_k[k] - rem[k];
                    chk($sformatf("data[%0d]", k), w_data[k], beat_of(cur[k], k, b));
                    chk($sformatf("last[%0d]", k), 64'(last_o[k]), 64'(rem[k] == 1));
                    chk($sformatf("idx[%0d]", k), 64'(w_idx[k]), 64'(b));
                end else begin
                    chk($sformatf("idle_last[%0d]", k), 64'(last_o[k]), 64'd0);
                    chk($sformatf("idle_idx[%0d]", k), 64'(w_idx[k]), 64'd0);
                end
            end
            s_fire[k] = valid_o[k] && ready;
            s_pop[k]  = pop_o[k] && avail;
            if (s_fire[k]) begin
                case (k)
                    0: begin log_d0.push_back(w_data[0]); log_c0.push_back(cyc); end
                    1: log_d1.push_back(w_data[1]);
                    default: begin log_d2.push_back(w_data[2]); log_c2.push_back(cyc); end
                endcase
            end
            if (k == 0 && pop_o[0]) log_p0.push_back(cyc);
        end
    end

    // After each edge: advance FIFO views and model, then re-present FIFO heads
    always @(posedge clk) begin
        #3;
        for (int k = 0; k < 3; k++) begin
            if (s_reset) begin
                rem[k] = 0;
            end else begin
                if (s_fire[k] && rem[k] != 0) rem[k] = rem[k] - 1;
                if (s_pop[k]) begin
                    cur[k] = ent[rd[k]];
                    rem[k] = ratio_k[k];
                end
            end
            if (s_pop[k]) rd[k] = rd[k] + 1;
            emp[k]  = (rd[k] >= ent.size());
            fdat[k] = emp[k] ? 64'hDEAD_BEEF_DEAD_BEEF : ent[rd[k]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] t2;
        int b0, b1, b2, bp, bc2, bd, j, guard, pushed;

        // Reset held with an empty FIFO
        cyc = 0;
        tick();
        tick();
        chk_en = 1'b1;
        repeat (10) tick();
        reset = 1'b0;
        tick();

        // Single entry, always ready
        t2 = 64'h4444_3333_2222_1111;
        b0 = log_d0.size(); b1 = log_d1.size(); b2 = log_d2.size();
        ready = 1'b1;
        ent.push_back(t2);
        repeat (8) tick();
        chk("t2_n0", 64'(log_d0.size() - b0), 64'd4);
        chk("t2_n2", 64'(log_d2.size() - b2), 64'd1);
        if (log_d0.size() - b0 >= 4 && log_d1.size() - b1 >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t2_lsb%0d", i), log_d0[b0+i], 64'(t2[16*i +: 16]));
                chk($sformatf("t2_msb%0d", i), log_d1[b1+i], 64'(t2[16*(3-i) +: 16]));
            end
        end
        if (log_d2.size() > b2) chk("t2_r1", log_d2[b2], t2);

        // Three preloaded entries stream without gaps
        b0 = log_c0.size(); bp = log_p0.size(); bc2 = log_c2.size();
        for (int i = 0; i < 3; i++) ent.push_back({$urandom, $urandom});
        repeat (16) tick();
        chk("t3_beats", 64'(log_c0.size() - b0), 64'd12);
        chk("t3_pops", 64'(log_p0.size() - bp), 64'd3);
        chk("t3_r1_beats", 64'(log_c2.size() - bc2), 64'd3);
        if (log_c0.size() - b0 >= 12 && log_p0.size() - bp >= 3 && log_c2.size() - bc2 >= 3) begin
            chk("t3_span", 64'(log_c0[b0+11] - log_c0[b0]), 64'd11);
            chk("t3_lat", 64'(log_c0[b0] - log_p0[bp]), 64'd1);
            chk("t3_pop1", 64'(log_p0[bp+1] - log_p0[bp]), 64'd4);
            chk("t3_pop2", 64'(log_p0[bp+2] - log_p0[bp]), 64'd8);
            chk("t3_r1_span", 64'(log_c2[bc2+2] - log_c2[bc2]), 64'd2);
        end

        // Reset while beat 2 of an entry is on the bus
        ready = 1'b0;
        for (int i = 0; i < 3; i++) ent.push_back({$urandom, $urandom});
        repeat (3) tick();
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        tick();
        chk("t5_idx", 64'(w_idx[0]), 64'd2);
        j = rd[0];
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bd = log_d0.size();
        ready = 1'b1;
        repeat (12) tick();
        if (log_d0.size() > bd) chk("t5_first", log_d0[bd], ent[j] & 64'hFFFF);
        else chk("t5_first_missing", 64'd0, 64'd1);

        // Random traffic with random backpressure
        pushed = 0;
        while (pushed < 200) begin
            ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                ent.push_back({$urandom, $urandom});
                pushed++;
            end
            tick();
        end
        guard = 0;
        while (!all_done() && guard < 6000) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        chk("drain_timeout", 64'(guard < 6000), 64'd1);
        ready = 1'b1;
        repeat (4) tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("pops_eq_entries[%0d]", k), 64'(rd[k]), 64'(ent.size()));
            chk($sformatf("final_valid[%0d]", k), 64'(valid_o[k]), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
